// File: rtl/fib_seq_gen.sv
// Fibonacci term generator.
// Walks F(0)..F(N_TERMS-1) upward one term per step tick. With mode 0 it then
// retraces back down to F(0) by subtraction; with mode 1 it stops at the top.
// The ascent turns around early if the next sum would not fit in WIDTH bits,
// and the sticky o_ovf flag records that this happened.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  S_IDLE    | waiting for i_start; outputs hold the last run's final term
//  S_INIT    | load F(0)/F(1) into cur/nxt, announce TERM=0, IDX=0
//  S_ASCEND  | on each tick: step up, or turn around at last index / carry
//  S_DESCEND | on each tick: step down; finish when IDX reaches 0
module fib_seq_gen #(
  parameter int WIDTH   = 11,
  parameter int N_TERMS = 16,
  parameter int CNT_W   = $clog2(N_TERMS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic             i_step_en,
  output logic [WIDTH-1:0] o_term,
  output logic [CNT_W-1:0] o_idx,
  output logic             o_term_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_ovf
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_INIT    = 2'd1,
    S_ASCEND  = 2'd2,
    S_DESCEND = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LP_IDX_LAST = CNT_W'(N_TERMS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_cur;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] w_cur_nxt;
  logic [WIDTH-1:0] w_nxt_nxt;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] w_idx_nxt;
  logic             r_mode;
  logic             w_mode_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_ovf;
  logic             w_ovf_nxt;
  logic [WIDTH:0]   w_sum;
  logic             w_carry;
  logic             w_last;

  // One extra bit on the sum so that its top bit is the overflow indication.
  assign w_sum   = {1'b0, r_cur} + {1'b0, r_nxt};
  assign w_carry = w_sum[WIDTH];
  assign w_last  = (r_idx == LP_IDX_LAST);

  // Next-state and next-datapath decode; everything holds unless a case moves it.
  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_nxt_nxt   = r_nxt;
    w_idx_nxt   = r_idx;
    w_mode_nxt  = r_mode;
    w_ovf_nxt   = r_ovf;
    w_valid_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_mode_nxt  = i_mode;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = S_INIT;
        end
      end
      S_INIT: begin
        w_cur_nxt   = '0;
        w_nxt_nxt   = WIDTH'(1);
        w_idx_nxt   = '0;
        w_valid_nxt = 1'b1;
        w_state_nxt = S_ASCEND;
      end
      S_ASCEND: begin
        if (i_step_en) begin
          if (w_last || w_carry) begin
            // Turnaround consumes this tick without touching the datapath.
            if (w_carry) begin
              w_ovf_nxt = 1'b1;
            end
            if (r_mode) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = S_DESCEND;
            end
          end else begin
            w_cur_nxt   = r_nxt;
            w_nxt_nxt   = w_sum[WIDTH-1:0];
            w_idx_nxt   = r_idx + CNT_W'(1);
            w_valid_nxt = 1'b1;
          end
        end
      end
      S_DESCEND: begin
        if (i_step_en) begin
          // nxt is always the successor of cur, so nxt - cur is never negative.
          w_cur_nxt   = r_nxt - r_cur;
          w_nxt_nxt   = r_cur;
          w_idx_nxt   = r_idx - CNT_W'(1);
          w_valid_nxt = 1'b1;
          if (r_idx == CNT_W'(1)) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cur   <= '0;
      r_nxt   <= '0;
      r_idx   <= '0;
      r_mode  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_nxt   <= w_nxt_nxt;
      r_idx   <= w_idx_nxt;
      r_mode  <= w_mode_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign o_term       = r_cur;
  assign o_idx        = r_idx;
  assign o_term_valid = r_valid;
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = r_done;
  assign o_ovf        = r_ovf;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Bench for fib_seq_gen: a default-width instance and an 8-bit instance that
// overflows early, both driven from one linear sequence of directed and
// randomized runs and compared against a list-based Fibonacci reference.
module tb_fib_seq_gen;

  localparam int WA     = 11;
  localparam int WB     = 8;
  localparam int NT     = 16;
  localparam int CW     = $clog2(NT);
  localparam int BUDGET = 2000;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic          step_en;
  logic          start_a;
  logic          start_b;
  logic [WA-1:0] term_a;
  logic [CW-1:0] idx_a;
  logic          tv_a, busy_a, done_a, ovf_a;
  logic [WB-1:0] term_b;
  logic [CW-1:0] idx_b;
  logic          tv_b, busy_b, done_b, ovf_b;

  int n_vec = 0;
  int n_err = 0;
  int exp_term[$];
  int exp_idx[$];
  bit exp_ovf;
  int got_term[$];
  int got_idx[$];
  int step_cnt = 0;

  always #5 clk = ~clk;

  fib_seq_gen #(.WIDTH(WA), .N_TERMS(NT)) u_dut_a (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start_a),
    .i_mode      (mode),
    .i_step_en   (step_en),
    .o_term      (term_a),
    .o_idx       (idx_a),
    .o_term_valid(tv_a),
    .o_busy      (busy_a),
    .o_done      (done_a),
    .o_ovf       (ovf_a)
  );

  fib_seq_gen #(.WIDTH(WB), .N_TERMS(NT)) u_dut_b (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start_b),
    .i_mode      (mode),
    .i_step_en   (step_en),
    .o_term      (term_b),
    .o_idx       (idx_b),
    .o_term_valid(tv_b),
    .o_busy      (busy_b),
    .o_done      (done_b),
    .o_ovf       (ovf_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: list of Fibonacci terms up to the last index or the first sum
  // that does not fit, followed (mode 0) by the same list reversed.
  task automatic build_exp(input int w, input int n, input bit m);
    longint a, b, tmp, lim;
    int     i;
    exp_term.delete();
    exp_idx.delete();
    exp_ovf = 1'b0;
    a = 0; b = 1; i = 0;
    lim = longint'(1) << w;
    exp_term.push_back(0);
    exp_idx.push_back(0);
    while (1) begin
      if (a + b >= lim) exp_ovf = 1'b1;
      if (exp_ovf || i == n - 1) break;
      tmp = a + b; a = b; b = tmp; i++;
      exp_term.push_back(int'(a));
      exp_idx.push_back(i);
    end
    if (!m) begin
      for (int k = exp_term.size() - 2; k >= 0; k--) begin
        exp_term.push_back(exp_term[k]);
        exp_idx.push_back(exp_idx[k]);
      end
    end
  endtask

  function automatic logic next_step(input int pat);
    logic s;
    case (pat)
      0:       s = 1'b1;
      1: begin s = (step_cnt % 5 == 0); step_cnt++; end
      default: s = ($urandom_range(0, 2) == 0);
    endcase
    return s;
  endfunction

  task automatic sample(input bit sel, output logic [31:0] t, output logic [31:0] ix,
                        output logic tv, output logic bz, output logic dn, output logic ov);
    if (sel) begin
      t = 32'(term_b); ix = 32'(idx_b); tv = tv_b; bz = busy_b; dn = done_b; ov = ovf_b;
    end else begin
      t = 32'(term_a); ix = 32'(idx_a); tv = tv_a; bz = busy_a; dn = done_a; ov = ovf_a;
    end
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) start_b = v; else start_a = v;
  endtask

  // One complete run on the selected instance; called at a falling edge.
  task automatic run(input string nm, input bit sel, input bit m, input int pat,
                     input bit inject, input bit chain);
    logic [31:0] t, ix, prev_t, prev_ix;
    logic        tv, bz, dn, ov, step_last;
    bit          seen_init, was_init, finished, injected;
    int          ticks, bad_hold, bad_tick, bad_busy, nmin;
    build_exp(sel ? WB : WA, NT, m);
    got_term.delete();
    got_idx.delete();
    seen_init = 0; finished = 0; injected = 0;
    ticks = 0; bad_hold = 0; bad_tick = 0; bad_busy = 0;
    sample(sel, prev_t, prev_ix, tv, bz, dn, ov);
    mode = m;
    set_start(sel, 1'b1);
    step_en = next_step(pat);
    for (int c = 1; c <= BUDGET; c++) begin
      step_last = step_en;
      @(negedge clk);
      set_start(sel, 1'b0);
      mode = 1'($urandom_range(0, 1));
      sample(sel, t, ix, tv, bz, dn, ov);
      was_init = seen_init;
      if (was_init && step_last) ticks++;
      if (tv) begin
        got_term.push_back(int'(t));
        got_idx.push_back(int'(ix));
        if (!seen_init) begin
          seen_init = 1;
          chk({nm, "_init_latency"}, 32'(c), 32'd2);
          chk({nm, "_ovf_cleared"}, {31'd0, ov}, 32'd0);
        end else if (!step_last) begin
          bad_tick++;
        end
      end else if (t !== prev_t || ix !== prev_ix) begin
        bad_hold++;
      end
      prev_t = t;
      prev_ix = ix;
      if (dn) begin
        finished = 1;
        chk({nm, "_busy_at_done"}, {31'd0, bz}, 32'd0);
        chk({nm, "_ovf_final"}, {31'd0, ov}, {31'd0, exp_ovf});
        break;
      end
      if (!bz) bad_busy++;
      if (inject && !injected && bz && got_term.size() == 3) begin
        set_start(sel, 1'b1);
        injected = 1;
      end
      step_en = next_step(pat);
    end
    chk({nm, "_done_seen"}, {31'd0, finished}, 32'd1);
    chk({nm, "_ticks"}, 32'(ticks), 32'(exp_term.size()));
    chk({nm, "_n_pulses"}, 32'(got_term.size()), 32'(exp_term.size()));
    nmin = (got_term.size() < exp_term.size()) ? got_term.size() : exp_term.size();
    for (int i = 0; i < nmin; i++) begin
      chk($sformatf("%s_term[%0d]", nm, i), 32'(got_term[i]), 32'(exp_term[i]));
      chk($sformatf("%s_idx[%0d]", nm, i), 32'(got_idx[i]), 32'(exp_idx[i]));
    end
    chk({nm, "_hold_without_valid"}, 32'(bad_hold), 32'd0);
    chk({nm, "_valid_without_tick"}, 32'(bad_tick), 32'd0);
    chk({nm, "_busy_during_run"}, 32'(bad_busy), 32'd0);
    if (finished && !chain) begin
      @(negedge clk);
      sample(sel, t, ix, tv, bz, dn, ov);
      chk({nm, "_done_single"}, {31'd0, dn}, 32'd0);
      chk({nm, "_idle_after"}, {31'd0, bz}, 32'd0);
      chk({nm, "_term_hold"}, t, prev_t);
    end
  endtask

  initial begin
    bit found, peak;
    rst = 1'b1; mode = 1'b0; step_en = 1'b0; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_term", 32'(term_a), 32'd0);
    chk("rst_idx", 32'(idx_a), 32'd0);
    chk("rst_valid", {31'd0, tv_a}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_done", {31'd0, done_a}, 32'd0);
    chk("rst_ovf", {31'd0, ovf_a}, 32'd0);
    chk("rst_b_busy", {31'd0, busy_b}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run("t1", 0, 0, 0, 0, 0);
    run("t2", 0, 1, 0, 0, 0);
    run("t3", 1, 0, 2, 0, 0);
    chk("t3_ovf_sticky", {31'd0, ovf_b}, 32'd1);
    run("t3b", 1, 1, 2, 0, 0);
    run("t4", 0, 0, 1, 1, 0);
    run("t6a", 0, 1, 2, 0, 1);
    run("t6b", 0, 0, 0, 0, 0);

    found = 0; peak = 0;
    mode = 1'b0; step_en = 1'b1; start_a = 1'b1;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (tv_a && peak && idx_a == CW'(7)) begin
        found = 1;
        break;
      end
      if (idx_a == CW'(NT - 1)) peak = 1;
    end
    chk("t5_reached_idx7", {31'd0, found}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_term", 32'(term_a), 32'd0);
    chk("t5_idx", 32'(idx_a), 32'd0);
    chk("t5_valid", {31'd0, tv_a}, 32'd0);
    chk("t5_busy", {31'd0, busy_a}, 32'd0);
    chk("t5_done", {31'd0, done_a}, 32'd0);
    chk("t5_ovf", {31'd0, ovf_a}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_no_done", {31'd0, done_a}, 32'd0);
    run("t5_rerun", 0, 0, 0, 0, 0);

    for (int r = 0; r < 6; r++) begin
      run($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          int'($urandom_range(1, 2)), 1'($urandom_range(0, 1)), (r < 5) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
